// File: rtl/psevdo_ram_fifo_ctrl_if.sv
// rtl/psevdo_ram_fifo_ctrl_if.sv - stream, RAM and status signal bundle for psevdo_ram_fifo_ctrl
interface psevdo_ram_fifo_ctrl_if #(
    parameter int DW = 9,
    parameter int AW = 8
) ();
    logic [DW-1:0]   IN_DATA;
    logic            IN_VALID;
    logic            IN_READY;
    logic [DW-1:0]   OUT_DATA;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic [DW-1:0]   RAM_DIN;
    logic [AW-1:0]   RAM_WADDR;
    logic [AW-1:0]   RAM_RADDR;
    logic            RAM_WRB;
    logic            RAM_RDB;
    logic [2:0]      RAM_DC;
    logic [DW-1:0]   RAM_DO1;
    logic [DW-1:0]   RAM_DO2;
    logic [AW+2:0]   LEVEL;
    logic            FULL;
    logic            EMPTY;
    logic            AFULL;
    logic            AEMPTY;

    // Controller side: consumes the input stream and RAM read data, drives everything else
    modport master (
        input  IN_DATA, IN_VALID, OUT_READY, RAM_DO1, RAM_DO2,
        output IN_READY, OUT_DATA, OUT_VALID,
        output RAM_DIN, RAM_WADDR, RAM_RADDR, RAM_WRB, RAM_RDB, RAM_DC,
        output LEVEL, FULL, EMPTY, AFULL, AEMPTY
    );

    // Environment side: producer, consumer and RAM
    modport slave (
        output IN_DATA, IN_VALID, OUT_READY, RAM_DO1, RAM_DO2,
        input  IN_READY, OUT_DATA, OUT_VALID,
        input  RAM_DIN, RAM_WADDR, RAM_RADDR, RAM_WRB, RAM_RDB, RAM_DC,
        input  LEVEL, FULL, EMPTY, AFULL, AEMPTY
    );
endinterface

// File: rtl/psevdo_ram_fifo_ctrl.sv
// rtl/psevdo_ram_fifo_ctrl.sv - FIFO controller over a 4-bank psevdo_ram_block with a 2-entry output buffer
module psevdo_ram_fifo_ctrl #(
    parameter int DW         = 9,
    parameter int AW         = 8,
    parameter int AFULL_LVL  = 1016,
    parameter int AEMPTY_LVL = 8
) (
    input  logic                    CLKS,
    input  logic                    RSTB,
    psevdo_ram_fifo_ctrl_if.master  bus
);
    localparam int PW = AW + 2;   // pointer width: 2 bank bits over the in-bank address
    localparam int LW = AW + 3;   // level width: must hold the full depth
    localparam logic [LW-1:0] DEPTH = LW'(1 << PW);

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] level;
    logic          prio_wr;       // 0: read wins the next bank conflict
    logic          inflight;      // a read was issued last cycle; RAM data arrives now
    logic          rd_bank_hi;    // bank of that read was 2 or 3 -> data on DO2
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;
    logic          buf_wr_idx;
    logic          buf_rd_idx;
    logic [1:0]    buf_cnt;

    logic          full;
    logic          empty;
    logic          out_valid;
    logic          pop;
    logic [2:0]    occ;
    logic          wr_req;
    logic          rd_req;
    logic [1:0]    w_bank;
    logic [1:0]    r_bank;
    logic          wr_gnt;
    logic          rd_gnt;
    logic          conflict;
    logic [DW-1:0] cap_data;

    assign full      = (level == DEPTH);
    assign empty     = (level == '0);
    assign out_valid = (buf_cnt != 2'd0);
    assign pop       = out_valid & bus.OUT_READY;

    // Buffered words plus the one in flight, after this cycle's pop, must leave room for another read
    assign occ    = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign wr_req = RSTB & bus.IN_VALID & ~full;
    assign rd_req = RSTB & ~empty & (occ < 3'd2);
    assign w_bank = wptr[PW-1:AW];
    assign r_bank = rptr[PW-1:AW];

    // Bank select is shared, so simultaneous requests to different banks take turns
    always_comb begin
        wr_gnt   = 1'b0;
        rd_gnt   = 1'b0;
        conflict = 1'b0;
        if (wr_req && rd_req) begin
            if (w_bank == r_bank) begin
                wr_gnt = 1'b1;
                rd_gnt = 1'b1;
            end else begin
                conflict = 1'b1;
                wr_gnt   = prio_wr;
                rd_gnt   = ~prio_wr;
            end
        end else begin
            wr_gnt = wr_req;
            rd_gnt = rd_req;
        end
    end

    assign bus.IN_READY  = wr_gnt;
    assign bus.RAM_WRB   = ~wr_gnt;
    assign bus.RAM_RDB   = ~rd_gnt;
    assign bus.RAM_DC    = {1'b0, (rd_gnt ? r_bank : w_bank)};
    assign bus.RAM_DIN   = bus.IN_DATA;
    assign bus.RAM_WADDR = wptr[AW-1:0];
    assign bus.RAM_RADDR = rptr[AW-1:0];
    assign bus.LEVEL     = level;
    assign bus.FULL      = full;
    assign bus.EMPTY     = empty;
    assign bus.AFULL     = (level >= LW'(AFULL_LVL));
    assign bus.AEMPTY    = (level <= LW'(AEMPTY_LVL));
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT_DATA  = buf_rd_idx ? buf1 : buf0;

    // Pointers, stored-word count and conflict priority advance on grants
    always_ff @(posedge CLKS or negedge RSTB) begin
        if (!RSTB) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            prio_wr <= 1'b0;
        end else begin
            if (wr_gnt) wptr <= wptr + 1'b1;
            if (rd_gnt) rptr <= rptr + 1'b1;
            if (wr_gnt && !rd_gnt)
                level <= level + 1'b1;
            else if (rd_gnt && !wr_gnt)
                level <= level - 1'b1;
            if (conflict) prio_wr <= ~prio_wr;
        end
    end

    // Remember that a read is in flight and which RAM output port it will appear on
    always_ff @(posedge CLKS or negedge RSTB) begin
        if (!RSTB) begin
            inflight   <= 1'b0;
            rd_bank_hi <= 1'b0;
        end else begin
            inflight <= rd_gnt;
            if (rd_gnt) rd_bank_hi <= r_bank[1];
        end
    end

    assign cap_data = rd_bank_hi ? bus.RAM_DO2 : bus.RAM_DO1;

    // Two-entry output buffer: capture the returning RAM word, pop on consumer handshake
    always_ff @(posedge CLKS or negedge RSTB) begin
        if (!RSTB) begin
            buf0       <= '0;
            buf1       <= '0;
            buf_wr_idx <= 1'b0;
            buf_rd_idx <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (inflight) begin
                if (buf_wr_idx) buf1 <= cap_data;
                else            buf0 <= cap_data;
                buf_wr_idx <= ~buf_wr_idx;
            end
            if (pop) buf_rd_idx <= ~buf_rd_idx;
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_psevdo_ram_fifo_ctrl.sv
// tb/tb_psevdo_ram_fifo_ctrl.sv - randomized scoreboard bench for psevdo_ram_fifo_ctrl
module tb_psevdo_ram_fifo_ctrl;
    logic CLKS = 1'b0;
    logic RSTB = 1'b0;

    always #5 CLKS = ~CLKS;

    psevdo_ram_fifo_ctrl_if bus ();

    psevdo_ram_fifo_ctrl dut (
        .CLKS (CLKS),
        .RSTB (RSTB),
        .bus  (bus)
    );

    // Behavioural 4-bank RAM: registered read data, DO1 for banks 0/1, DO2 for banks 2/3
    logic [8:0] ram [4][256];
    always @(posedge CLKS) begin
        if (!bus.RAM_WRB) ram[bus.RAM_DC[1:0]][bus.RAM_WADDR] <= bus.RAM_DIN;
        if (!bus.RAM_RDB) begin
            if (!bus.RAM_DC[1]) bus.RAM_DO1 <= ram[bus.RAM_DC[1:0]][bus.RAM_RADDR];
            else                bus.RAM_DO2 <= ram[bus.RAM_DC[1:0]][bus.RAM_RADDR];
        end
    end

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    int         wcnt, rcnt, pcnt, level_exp;
    int         acc_count = 0;
    int         drv_acc   = 0;
    int         pat_i     = 0;
    bit         rd_last, prio_wr_m;
    logic [8:0] seq_word  = 9'd0;

    int m_occ, m_wb, m_rb;
    bit m_ov, m_pop, m_wrq, m_rdq, m_ewr, m_erd, m_conf, m_wr, m_rd;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: derives the expected behaviour from counts of words written, read and popped
    always @(negedge CLKS) begin
        if (!RSTB) begin
            chk("rst_wrb", int'(bus.RAM_WRB), 1);
            chk("rst_rdb", int'(bus.RAM_RDB), 1);
            chk("rst_in_ready", int'(bus.IN_READY), 0);
            chk("rst_out_valid", int'(bus.OUT_VALID), 0);
            exp_q.delete();
            wcnt = 0; rcnt = 0; pcnt = 0; level_exp = 0;
            rd_last = 1'b0; prio_wr_m = 1'b0;
        end else begin
            m_occ = rcnt - pcnt;
            m_ov  = (m_occ - (rd_last ? 1 : 0)) > 0;
            m_pop = m_ov && bus.OUT_READY;
            m_wrq = bus.IN_VALID && (level_exp < 1024);
            m_rdq = (level_exp > 0) && ((m_occ - (m_pop ? 1 : 0)) < 2);
            m_wb  = (wcnt / 256) % 4;
            m_rb  = (rcnt / 256) % 4;
            m_conf = 1'b0;
            if (m_wrq && m_rdq) begin
                if (m_wb == m_rb) begin
                    m_ewr = 1'b1; m_erd = 1'b1;
                end else begin
                    m_conf = 1'b1;
                    m_ewr = prio_wr_m; m_erd = !prio_wr_m;
                end
            end else begin
                m_ewr = m_wrq; m_erd = m_rdq;
            end
            m_wr = !bus.RAM_WRB;
            m_rd = !bus.RAM_RDB;

            chk("level", int'(bus.LEVEL), level_exp);
            chk("full", int'(bus.FULL), int'(level_exp == 1024));
            chk("empty", int'(bus.EMPTY), int'(level_exp == 0));
            chk("afull", int'(bus.AFULL), int'(level_exp >= 1016));
            chk("aempty", int'(bus.AEMPTY), int'(level_exp <= 8));
            chk("out_valid", int'(bus.OUT_VALID), int'(m_ov));
            chk("wr_grant", int'(m_wr), int'(m_ewr));
            chk("rd_grant", int'(m_rd), int'(m_erd));
            chk("in_ready", int'(bus.IN_READY), int'(m_ewr));
            if (m_wr) begin
                chk("wr_dc", int'(bus.RAM_DC), m_wb);
                chk("wr_addr", int'(bus.RAM_WADDR), wcnt % 256);
            end
            if (m_rd) begin
                chk("rd_dc", int'(bus.RAM_DC), m_rb);
                chk("rd_addr", int'(bus.RAM_RADDR), rcnt % 256);
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pop_empty: got word %0d, expected no output", bus.OUT_DATA);
                end else begin
                    chk("out_data", int'(bus.OUT_DATA), int'(exp_q.pop_front()));
                end
                pcnt++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back(bus.IN_DATA);
                acc_count++;
            end
            wcnt      += m_wr ? 1 : 0;
            rcnt      += m_rd ? 1 : 0;
            level_exp += (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
            chk("credit", int'((rcnt - pcnt) <= 2), 1);
            rd_last = m_rd;
            if (m_conf) prio_wr_m = !prio_wr_m;
        end
    end

    task automatic set_ready(input int rmode);
        case (rmode)
            0: bus.OUT_READY = 1'b1;
            1: bus.OUT_READY = 1'b0;
            2: bus.OUT_READY = 1'($urandom_range(0, 1));
            default: bus.OUT_READY = ((pat_i % 4) == 0) || ((pat_i % 4) == 3);
        endcase
        pat_i++;
    endtask

    // Random producer: holds a word until accepted, then decides on the next one
    task automatic drive(input int n, input int vpct, input int rmode, input bit seq);
        for (int i = 0; i < n; i++) begin
            @(posedge CLKS); #1;
            if (acc_count != drv_acc) begin
                drv_acc  = acc_count;
                seq_word = seq_word + 9'd1;
                bus.IN_VALID = 1'b0;
            end
            if (!bus.IN_VALID) begin
                bus.IN_VALID = ($urandom_range(0, 99) < vpct);
                bus.IN_DATA  = seq ? seq_word : 9'($urandom);
            end
            set_ready(rmode);
        end
    endtask

    task automatic send_word(input logic [8:0] w);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = w;
        for (int k = 0; k < 64; k++) begin
            @(negedge CLKS);
            if (bus.IN_READY) return;
        end
        n_tests++; n_fail++;
        $display("FAIL send_timeout: got no IN_READY in 64 cycles, expected acceptance");
    endtask

    task automatic fill_to(input int target);
        bus.OUT_READY = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(posedge CLKS); #1;
            if (acc_count != drv_acc) begin
                drv_acc  = acc_count;
                seq_word = seq_word + 9'd1;
            end
            if (level_exp >= target) break;
            bus.IN_VALID = 1'b1;
            bus.IN_DATA  = seq_word;
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge CLKS); #3;
        RSTB = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        repeat (2) @(posedge CLKS);
        #3 RSTB = 1'b1;
        drv_acc = acc_count;
    endtask

    int acc_base;
    int lat;

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = 9'd0;
        bus.OUT_READY = 1'b0;
        repeat (3) @(posedge CLKS);
        #1;
        chk("reset_level", int'(bus.LEVEL), 0);
        chk("reset_empty", int'(bus.EMPTY), 1);
        chk("reset_full", int'(bus.FULL), 0);
        chk("reset_afull", int'(bus.AFULL), 0);
        chk("reset_aempty", int'(bus.AEMPTY), 1);
        chk("reset_out_data", int'(bus.OUT_DATA), 0);
        #2 RSTB = 1'b1;

        // 1: three words, first-word latency
        bus.OUT_READY = 1'b1;
        send_word(9'h001);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b0;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLKS);
            lat++;
            if (bus.OUT_VALID) break;
        end
        chk("t1_latency", lat, 3);
        send_word(9'h002);
        send_word(9'h1FF);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b0;
        repeat (8) @(posedge CLKS);
        #1;
        chk("t1_out_count", pcnt, 3);
        chk("t1_queue_left", exp_q.size(), 0);

        // 2: fill to FULL with the consumer stalled, then drain
        reset_pulse();
        seq_word = 9'd0;
        acc_base = acc_count;
        drive(1100, 100, 1, 1'b1);
        @(negedge CLKS);
        chk("t2_level", int'(bus.LEVEL), 1024);
        chk("t2_full", int'(bus.FULL), 1);
        chk("t2_afull", int'(bus.AFULL), 1);
        chk("t2_in_ready", int'(bus.IN_READY), 0);
        chk("t2_accepted", acc_count - acc_base, 1026);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b0;
        drive(1100, 0, 0, 1'b1);
        chk("t2_popped", pcnt, 1026);
        chk("t2_empty", int'(bus.EMPTY), 1);
        chk("t2_queue_left", exp_q.size(), 0);

        // 3: full-rate streaming across several pointer wraps
        reset_pulse();
        acc_base = acc_count;
        drive(3100, 100, 0, 1'b0);
        chk("t3_rate", int'((acc_count - acc_base) >= 3000), 1);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b0;
        drive(20, 0, 0, 1'b0);
        chk("t3_queue_left", exp_q.size(), 0);

        // 4: read in bank 0, write in bank 1 -> alternating grants starting with read
        reset_pulse();
        fill_to(300);
        for (int k = 0; k < 6; k++) begin
            @(posedge CLKS); #1;
            if (acc_count != drv_acc) begin
                drv_acc = acc_count;
                bus.IN_DATA = 9'($urandom);
            end
            bus.IN_VALID  = 1'b1;
            bus.OUT_READY = 1'b1;
            @(negedge CLKS);
            chk("t4_alt_rd", int'(!bus.RAM_RDB), int'((k % 2) == 0));
            chk("t4_alt_wr", int'(!bus.RAM_WRB), int'((k % 2) == 1));
        end
        drive(200, 100, 2, 1'b0);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b0;
        drive(700, 0, 0, 1'b0);
        chk("t4_queue_left", exp_q.size(), 0);
        reset_pulse();
        drive(10, 100, 0, 1'b0);
        @(negedge CLKS);
        chk("t4_same_bank_both", int'({!bus.RAM_WRB, !bus.RAM_RDB}), 3);

        // 5: consumer pattern 1,0,0,1 under random input
        reset_pulse();
        pat_i = 0;
        drive(1500, 90, 3, 1'b0);
        @(posedge CLKS); #1;
        bus.IN_VALID = 1'b0;
        drive(1200, 0, 0, 1'b0);
        chk("t5_queue_left", exp_q.size(), 0);

        // 6: reset mid-stream at LEVEL 500
        reset_pulse();
        fill_to(500);
        @(negedge CLKS);
        chk("t6_level_before", int'(bus.LEVEL), 500);
        @(posedge CLKS); #3;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 9'h0AB;
        RSTB = 1'b0;
        #1;
        chk("t6_rst_out_valid", int'(bus.OUT_VALID), 0);
        chk("t6_rst_wrb", int'(bus.RAM_WRB), 1);
        chk("t6_rst_rdb", int'(bus.RAM_RDB), 1);
        chk("t6_rst_in_ready", int'(bus.IN_READY), 0);
        chk("t6_rst_level", int'(bus.LEVEL), 0);
        repeat (2) @(posedge CLKS);
        #3 RSTB = 1'b1;
        @(negedge CLKS);
        chk("t6_level_after", int'(bus.LEVEL), 0);
        chk("t6_in_ready_after", int'(bus.IN_READY), 1);
        @(posedge CLKS); #1;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b1;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLKS);
            lat++;
            if (bus.OUT_VALID) break;
        end
        chk("t6_first_out", int'(bus.OUT_DATA), 9'h0AB);
        repeat (5) @(posedge CLKS);
        #1;
        chk("t6_queue_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus by time limit, expected completion");
        $fatal(1);
    end
endmodule
